// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control encodings (FSM states, register width, control-bus bit indices)
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
    localparam int REG_W = 4;
    localparam int SIG_REG_WRITE = 9;
    localparam int SIG_WB_SEL = 8;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that saturates at all-ones, cleared by asynchronous reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / memory-wait stall and taken-branch flush control for the 5-stage pipeline.
// Define HAZ_PERF_EN to add the stall_cycles / flush_count performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 4,
    parameter int LU_BUBBLES = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             idex_bubble,
    output logic             memwb_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             mem_timeout,
    output logic [1:0]       state
`ifdef HAZ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    import pipe_ctrl_pkg::*;

    state_t     state_q, state_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       load_use, mem_wait, flush, mstall, lstall, tmo;

    assign load_use = ex_mem_read & ((id_rn_used & (id_rn == ex_rd)) | (id_rm_used & (id_rm == ex_rd)));
    assign mem_wait = mem_req & ~mem_ready;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= RUN;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
        end

    always_comb begin
        flush   = 1'b0;
        mstall  = 1'b0;
        lstall  = 1'b0;
        tmo     = 1'b0;
        state_d = RUN;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN, LOAD_STALL: begin
                if (br_taken) flush = 1'b1;
                else if (mem_wait) begin
                    mstall  = 1'b1;
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd1;
                end else if (state_q == LOAD_STALL) begin
                    lstall  = 1'b1;
                    bcnt_d  = bcnt_q - 2'd1;
                    state_d = (bcnt_q == 2'd1) ? RUN : LOAD_STALL;
                end else if (load_use) begin
                    lstall = 1'b1;
                    if (LU_BUBBLES > 1) begin
                        state_d = LOAD_STALL;
                        bcnt_d  = 2'(LU_BUBBLES - 1);
                    end
                end
            end
            // branch is ignored here: the memory stage holds the memory instruction
            MEM_WAIT: begin
                if (mem_wait && wcnt_q == 8'(MEM_TIMEOUT)) tmo = 1'b1;
                else if (mem_wait) begin
                    mstall  = 1'b1;
                    wcnt_d  = wcnt_q + 8'd1;
                    state_d = MEM_WAIT;
                end
            end
            default: ;
        endcase
    end

    assign pc_en        = ~reset & ~mstall & ~lstall;
    assign ifid_en      = ~reset & ~mstall & ~lstall;
    assign idex_en      = ~reset & ~mstall;
    assign exmem_en     = ~reset & ~mstall;
    assign idex_bubble  = ~reset & lstall;
    assign memwb_bubble = ~reset & mstall;
    assign flush_ifid   = reset | flush;
    assign flush_idex   = reset | flush;
    assign flush_exmem  = reset | flush;
    assign mem_timeout  = ~reset & tmo;
    assign state        = state_q;

`ifdef HAZ_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(~pc_en), .cnt(stall_cycles));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(flush_ifid), .cnt(flush_count));
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with directed hazard/wait/timeout/reset cases plus random traffic
module tb_pipeline_hazard_ctrl;
    localparam int LU = 2;
    localparam int MT = 15;
    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] id_rn = '0, id_rm = '0, ex_rd = '0;
    logic       id_rn_used = 1'b0, id_rm_used = 1'b0, ex_mem_read = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0, br_taken = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en, idex_bubble, memwb_bubble;
    logic       flush_ifid, flush_idex, flush_exmem, mem_timeout;
    logic [1:0] state;
`ifdef HAZ_PERF_EN
    logic [CW-1:0] stall_cycles, flush_count;
`endif

    pipeline_hazard_ctrl #(.REG_W(4), .LU_BUBBLES(LU), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used),
        .id_rm_used(id_rm_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_req(mem_req),
        .mem_ready(mem_ready), .br_taken(br_taken), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .idex_bubble(idex_bubble),
        .memwb_bubble(memwb_bubble), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .mem_timeout(mem_timeout), .state(state)
`ifdef HAZ_PERF_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        int          ps;
        int          pf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0, fails = 0, cyc = 0;
    int   lu_left = 0, stalled = 0, perf_s = 0, perf_f = 0;
    logic [11:0] dut_v;

    assign dut_v = {pc_en, ifid_en, idex_en, exmem_en, idex_bubble, memwb_bubble,
                    flush_ifid, flush_idex, flush_exmem, mem_timeout, state};

    always @(negedge clk)
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            tests++;
            if (dut_v !== mon_e.v) begin
                fails++;
                $display("FAIL ctrl cyc=%0d got=%b exp=%b", mon_e.cyc, dut_v, mon_e.v);
            end
`ifdef HAZ_PERF_EN
            tests++;
            if (int'(stall_cycles) != mon_e.ps || int'(flush_count) != mon_e.pf) begin
                fails++;
                $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", mon_e.cyc, stall_cycles, flush_count, mon_e.ps, mon_e.pf);
            end
`endif
        end

    // Reference model: tracks remaining bubbles and consecutive memory-stall cycles as plain integers
    task automatic step(input logic r, input logic [3:0] rn, input logic [3:0] rm, input logic rnu,
                        input logic rmu, input logic [3:0] rd, input logic mr, input logic mq,
                        input logic my, input logic br);
        logic en_f, en_b, bub_i, bub_w, fl, to, lu, mw;
        logic [1:0] st;
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; id_rn = rn; id_rm = rm; id_rn_used = rnu; id_rm_used = rmu;
        ex_rd = rd; ex_mem_read = mr; mem_req = mq; mem_ready = my; br_taken = br;
        cyc++;
        en_f = 1; en_b = 1; bub_i = 0; bub_w = 0; fl = 0; to = 0;
        lu = mr & ((rnu & (rn == rd)) | (rmu & (rm == rd)));
        mw = mq & ~my;
        st = 2'd0;
        if (r) begin
            en_f = 0; en_b = 0; fl = 1;
            lu_left = 0; stalled = 0; perf_s = 0; perf_f = 0;
        end else begin
            st = stalled > 0 ? 2'd2 : lu_left > 0 ? 2'd1 : 2'd0;
            if (stalled > 0) begin
                if (!mw) stalled = 0;
                else if (stalled == MT) begin to = 1; stalled = 0; end
                else begin en_f = 0; en_b = 0; bub_w = 1; stalled++; end
            end else if (br) begin
                fl = 1; lu_left = 0;
            end else if (mw) begin
                en_f = 0; en_b = 0; bub_w = 1; stalled = 1; lu_left = 0;
            end else if (lu_left > 0) begin
                en_f = 0; bub_i = 1; lu_left--;
            end else if (lu) begin
                en_f = 0; bub_i = 1; lu_left = LU - 1;
            end
        end
        e.v = {en_f, en_f, en_b, en_b, bub_i, bub_w, fl, fl, fl, to, st};
        e.ps = perf_s;
        e.pf = perf_f;
        e.cyc = cyc;
        q.push_back(e);
        if (!r) begin
            if (!en_f && perf_s < (1 << CW) - 1) perf_s++;
            if (fl && perf_f < (1 << CW) - 1) perf_f++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 3, 5, 1, 0, 3, 1, 0, 0, 0);
        step(0, 3, 5, 1, 0, 3, 1, 0, 0, 0);
        step(0, 3, 5, 1, 0, 7, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        idle(2);
        step(0, 3, 5, 1, 0, 3, 1, 0, 0, 1);
        idle(1);
        step(0, 1, 3, 0, 1, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, i == 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(2);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 149) == 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
